// File: rtl/gcd_arbiter.sv
`timescale 1ns/1ps
// gcd_arbiter: round-robin scheduler sharing one go/done GCD core among N requesters.
// Optional build macro GCD_ARB_TIMEOUT_EN aborts a stuck WAIT after TIMEOUT cycles.
module gcd_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_x,
    input  logic [N*W-1:0] req_y,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_gcd,
    output logic           rsp_err,
    output logic           core_go,
    output logic [W-1:0]   core_x,
    output logic [W-1:0]   core_y,
    input  logic           core_done,
    input  logic [W-1:0]   core_gcd
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    if (N < 2 || N > 8) begin : g_bad_n
        $error("gcd_arbiter: N must be in 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("gcd_arbiter: TIMEOUT must be at least 1");
    end

    state_e        state_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] gnt_idx_q;
    logic [N-1:0]  gnt_q;
    logic [N-1:0]  rsp_valid_q;
    logic [W-1:0]  rsp_gcd_q;
    logic          rsp_err_q;
    logic          core_go_q;
    logic [W-1:0]  core_x_q;
    logic [W-1:0]  core_y_q;

    logic          win_found_c;
    logic [IW-1:0] win_idx_c;
    logic [N-1:0]  win_oh_c;
    logic [W-1:0]  win_x_c;
    logic [W-1:0]  win_y_c;
    logic [IW-1:0] rr_next_c;
    logic          timeout_hit_c;

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin : p_pick
        logic [IW-1:0] cand;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IW'((32'(rr_ptr_q) + off) % N);
            if (!win_found_c && req[cand]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand;
            end
        end
    end

    assign win_oh_c  = N'(1) << win_idx_c;
    assign win_x_c   = req_x[32'(win_idx_c) * W +: W];
    assign win_y_c   = req_y[32'(win_idx_c) * W +: W];
    assign rr_next_c = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + IW'(1);

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_q;

    // Counts WAIT cycles that end without core_done; cleared on every issue.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_WAIT && !core_done) begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
        end
    end

    assign timeout_hit_c = (state_q == S_WAIT) && (wait_cnt_q + CW'(1) == CW'(TIMEOUT));
`else
    assign timeout_hit_c = 1'b0;
`endif

    // Transaction FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_gcd_q   <= '0;
            rsp_err_q   <= 1'b0;
            core_go_q   <= 1'b0;
            core_x_q    <= '0;
            core_y_q    <= '0;
        end else begin
            core_go_q   <= 1'b0;
            rsp_valid_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (win_found_c) begin
                        gnt_q     <= win_oh_c;
                        gnt_idx_q <= win_idx_c;
                        core_x_q  <= win_x_c;
                        core_y_q  <= win_y_c;
                        // A zero operand would hang the subtractive core.
                        if (win_x_c == '0 || win_y_c == '0) begin
                            rsp_valid_q <= win_oh_c;
                            rsp_gcd_q   <= win_x_c | win_y_c;
                            rsp_err_q   <= 1'b0;
                            state_q     <= S_RESP;
                        end else begin
                            core_go_q <= 1'b1;
                            state_q   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        rsp_valid_q <= gnt_q;
                        rsp_gcd_q   <= core_gcd;
                        rsp_err_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else if (timeout_hit_c) begin
                        rsp_valid_q <= gnt_q;
                        rsp_gcd_q   <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    gnt_q     <= '0;
                    rsp_gcd_q <= '0;
                    rsp_err_q <= 1'b0;
                    rr_ptr_q  <= rr_next_c;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_gcd   = rsp_gcd_q;
    assign rsp_err   = rsp_err_q;
    assign core_go   = core_go_q;
    assign core_x    = core_x_q;
    assign core_y    = core_y_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
`timescale 1ns/1ps
// Directed bench for gcd_arbiter; the bench itself plays the GCD core.
module tb_gcd_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_x;
    logic [N*W-1:0] req_y;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_gcd;
    logic           rsp_err;
    logic           core_go;
    logic [W-1:0]   core_x;
    logic [W-1:0]   core_y;
    logic           core_done;
    logic [W-1:0]   core_gcd;

    int vectors     = 0;
    int miscompares = 0;

    gcd_arbiter #(.N(N), .W(W), .TIMEOUT(64)) dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_gcd   (rsp_gcd),
        .rsp_err   (rsp_err),
        .core_go   (core_go),
        .core_x    (core_x),
        .core_y    (core_y),
        .core_done (core_done),
        .core_gcd  (core_gcd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
    endtask

    // One core-path transaction with core_done in the first WAIT cycle.
    task automatic run_core(input int g, input logic [W-1:0] res);
        tick();
        chk("rr_gnt", 32'(gnt), 32'(1) << g);
        chk("rr_go", 32'(core_go), 32'd1);
        tick();
        core_done = 1'b1;
        core_gcd  = res;
        tick();
        chk("rr_rsp_valid", 32'(rsp_valid), 32'(1) << g);
        chk("rr_rsp_gcd", 32'(rsp_gcd), 32'(res));
        core_done = 1'b0;
        tick();
        chk("rr_gnt_clear", 32'(gnt), 32'd0);
    endtask

    initial begin
        int exp_a[5];
        int exp_b[3];
        int n;
        exp_a = '{0, 1, 2, 3, 0};
        exp_b = '{1, 3, 1};
        req = '0; req_x = '0; req_y = '0; core_done = 1'b0; core_gcd = '0;

        #2 clr = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_core_go", 32'(core_go), 32'd0);
        chk("rst_core_x", 32'(core_x), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        tick();
        clr = 1'b1;

        // Fairness with every requester held high, then a sparse pattern.
        for (int i = 0; i < 4; i++) set_op(i, 4'd6, 4'd9);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) run_core(exp_a[k], 4'd3);
        req = 4'b1010;
        for (int k = 0; k < 3; k++) run_core(exp_b[k], 4'd3);
        req = '0;

        // Core path with core_done two cycles after core_go.
        set_op(0, 4'd12, 4'd8);
        req = 4'b0001;
        tick();
        chk("core_gnt", 32'(gnt), 32'h1);
        chk("core_go", 32'(core_go), 32'd1);
        chk("core_x", 32'(core_x), 32'd12);
        chk("core_y", 32'(core_y), 32'd8);
        tick();
        chk("core_go_once", 32'(core_go), 32'd0);
        tick();
        chk("core_wait_no_rsp", 32'(rsp_valid), 32'd0);
        core_done = 1'b1;
        core_gcd  = 4'd4;
        tick();
        chk("core_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("core_rsp_gcd", 32'(rsp_gcd), 32'd4);
        chk("core_rsp_err", 32'(rsp_err), 32'd0);
        core_done = 1'b0;
        req = '0;
        tick();
        chk("core_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("core_gnt_clear", 32'(gnt), 32'd0);

        // Zero-operand bypass.
        set_op(1, 4'd0, 4'd9);
        req = 4'b0010;
        tick();
        chk("byp_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("byp_rsp_gcd", 32'(rsp_gcd), 32'd9);
        chk("byp_no_go", 32'(core_go), 32'd0);
        req = '0;
        tick();
        chk("byp_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        set_op(1, 4'd0, 4'd0);
        req = 4'b0010;
        tick();
        chk("byp00_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("byp00_rsp_gcd", 32'(rsp_gcd), 32'd0);
        req = '0;
        tick();

        // Stray core_done while idle.
        core_done = 1'b1;
        core_gcd  = 4'd7;
        tick();
        chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stray_gnt", 32'(gnt), 32'd0);
        core_done = 1'b0;
        tick();

        // Late drop and operand change after grant.
        set_op(2, 4'd6, 4'd4);
        req = 4'b0100;
        tick();
        chk("late_gnt", 32'(gnt), 32'h4);
        chk("late_go", 32'(core_go), 32'd1);
        req = '0;
        set_op(2, 4'd15, 4'd15);
        tick();
        chk("late_core_x_held", 32'(core_x), 32'd6);
        core_done = 1'b1;
        core_gcd  = 4'd2;
        tick();
        chk("late_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("late_rsp_gcd", 32'(rsp_gcd), 32'd2);
        core_done = 1'b0;
        tick();

        // Asynchronous reset in the middle of WAIT.
        set_op(0, 4'd12, 4'd8);
        req = 4'b0001;
        tick();
        tick();
        tick();
        clr = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_go", 32'(core_go), 32'd0);
        chk("mid_rst_core_x", 32'(core_x), 32'd0);
        chk("mid_rst_core_y", 32'(core_y), 32'd0);
        tick();
        clr = 1'b1;
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        chk("post_rst_go", 32'(core_go), 32'd1);
        chk("post_rst_core_x", 32'(core_x), 32'd12);
        tick();
        chk("post_rst_go_once", 32'(core_go), 32'd0);

`ifdef GCD_ARB_TIMEOUT_EN
        n = 0;
        while (rsp_valid == '0 && n < 100) begin
            tick();
            n++;
        end
        chk("to_wait_cycles", 32'(n), 32'd64);
        chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_gcd", 32'(rsp_gcd), 32'd0);
        req = '0;
        tick();
        chk("to_rsp_one_cycle", 32'(rsp_valid), 32'd0);
`else
        n = 0;
        repeat (100) begin
            tick();
            if (rsp_valid != '0) n++;
        end
        chk("nto_no_rsp", 32'(n), 32'd0);
        chk("nto_gnt_held", 32'(gnt), 32'h1);
        core_done = 1'b1;
        core_gcd  = 4'd4;
        tick();
        chk("nto_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("nto_rsp_gcd", 32'(rsp_gcd), 32'd4);
        chk("nto_rsp_err", 32'(rsp_err), 32'd0);
        core_done = 1'b0;
        req = '0;
        tick();
`endif
        tick();
        chk("end_gnt", 32'(gnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
- Round-robin scheduler that shares one GCD core (go/done handshake, W-bit operands) among N requesters.
- Sits between the requesters and the core. Grants one request at a time, latches its operands, issues `core_go` and waits for `core_done`.
- Returns the result to the granted requester with a one-cycle response strobe.
- Zero operands bypass the core, because the subtractive core never terminates on a zero operand.

Parameters:
- N, 4: number of requesters, 2..8.
- W, 4: operand and result width in bits.
- TIMEOUT, 64: maximum WAIT cycles before abort; used only with GCD_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous reset, active-low (0 = reset).
- req  input  N  per-requester request level; held high until that requester's rsp_valid bit.
- req_x  input  N*W  operand x; requester i occupies bits [i*W +: W].
- req_y  input  N*W  operand y; same packing as req_x.
- gnt  output  N  one-hot; grant to requester i, high for the whole transaction.
- rsp_valid  output  N  one-hot one-cycle strobe to requester i: result valid.
- rsp_gcd  output  W  result; valid only while rsp_valid != 0.
- rsp_err  output  1  high with rsp_valid when the transaction timed out.
- core_go  output  1  one-cycle start pulse to the GCD core.
- core_x  output  W  latched x to the core; stable from ISSUE through WAIT.
- core_y  output  W  latched y to the core; stable from ISSUE through WAIT.
- core_done  input  1  core completion strobe, sampled only in WAIT.
- core_gcd  input  W  core result, sampled when core_done = 1.

Behaviour:
- Reset (clr=0, async): state=IDLE, rr_ptr=0. gnt, rsp_valid, rsp_gcd, rsp_err, core_go, core_x, core_y and the timeout counter all = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, select the first set bit at or after rr_ptr, wrapping modulo N.
  - Set gnt for the winner and latch its x and y.
  - If x==0 or y==0: result = x|y (gcd(0,0)=0) and go to RESP. No core_go is issued.
  - Otherwise go to ISSUE.
- ISSUE: core_go=1 for exactly one cycle, then WAIT; timeout counter cleared.
- WAIT:
  - On core_done=1: latch core_gcd, go to RESP.
  - A core_done arriving in any other state is ignored.
- RESP:
  - rsp_valid[g]=1 and rsp_gcd = result for exactly one cycle.
  - rr_ptr <= (g+1) mod N; gnt cleared; next state IDLE.
- Latency, req rise to rsp_valid:
  - Bypass: 2 cycles (IDLE sample, RESP).
  - Core path: 3 + core cycles. With core_done in the first WAIT cycle, rsp_valid is at cycle 4.
- Back-to-back: at most one transaction per IDLE visit; a new grant is possible the cycle after RESP.
- Requester behaviour:
  - Deasserting req before it is granted drops the request.
  - Deasserting req after it is granted does not abort; the response is still issued.
  - Operand changes after the grant are ignored.
- Fairness: with all N requests held high, grants rotate 0,1,...,N-1,0,...
- Reset mid-transaction: everything returns to reset values immediately. core_go is never left high. A pending core result is lost.
- rsp_err=0 except on a timeout, when the optional feature is enabled.

Optional Feature:
- Macro: GCD_ARB_TIMEOUT_EN.
- Enabled: a counter (clog2(TIMEOUT+1) bits) increments each WAIT cycle without core_done.
  - When the count reaches TIMEOUT, go to RESP with rsp_gcd=0 and rsp_err=1.
  - core_done in the same cycle as the timeout: done wins, rsp_err=0.
- Disabled: no counter; WAIT lasts until core_done; rsp_err is tied 0.

Test Plan:
- Reset: clr=0 mid-WAIT → all outputs 0 immediately. After clr=1 with req=0001, x=12, y=8 → gnt=0001, one core_go pulse.
- Core path: req=0001, x=12, y=8, core_done two cycles after core_go with core_gcd=4 → rsp_valid=0001, rsp_gcd=4, rsp_err=0, exactly one cycle.
- Bypass: req=0010, x=0, y=9 → rsp_valid=0010, rsp_gcd=9 two cycles after req, no core_go. A second request with x=0, y=0 → rsp_gcd=0.
- Round-robin: req=1111 held, each core_done one cycle after core_go → grant order 0,1,2,3,0. Then with req=1010 held and the last grant on 0 → grants 1,3,1.
- Stray done and late drop: core_done pulsed in IDLE → ignored. Requester 2 drops req after its grant → rsp_valid=0100 is still issued.
- Timeout (GCD_ARB_TIMEOUT_EN, TIMEOUT=64): core_done never asserted → rsp_valid=0001, rsp_err=1, rsp_gcd=0 after 64 WAIT cycles. Without the macro → the arbiter stays in WAIT.
